// File: rtl/basys3_top.sv
// basys3_top -- board-level top for the Basys3 LED/switch demo.
//
// The 16 slide switches are synchronised into the 100 MHz domain. The two
// top switches pick a display mode for the 16 user LEDs:
//   00  pass-through of sw[13:0]
//   01  14-bit up/down counter, stepped on each animation tick
//       (sw[0]=0 counts up, sw[0]=1 counts down)
//   10  14-bit rotating pattern, loaded from sw[13:0] on entry to the mode
//   11  inverted sw[13:0]
// LED[15:14] always shows the active mode.
//
// Ports:
//   CLK100MHZ   in   1   system clock, rising edge
//   CPU_RESETN  in   1   asynchronous active-low reset
//   sw          in  16   slide switches (asynchronous to the clock)
//   LED         out 16   user LEDs, registered
//
// Parameters:
//   SYNC_STAGES  flip-flop stages per switch input (>= 2)
//   TICK_DIV     clocks between animation ticks (>= 2)

module basys3_top #(
  parameter int SYNC_STAGES = 2,
  parameter int TICK_DIV    = 10_000_000
) (
  input  logic        CLK100MHZ,
  input  logic        CPU_RESETN,
  input  logic [15:0] sw,
  output logic [15:0] LED
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    MODE_PASS = 2'b00,
    MODE_CNT  = 2'b01,
    MODE_ROT  = 2'b10,
    MODE_INV  = 2'b11
  } mode_t;

  // An all-zero pattern would rotate invisibly, so seed a single lit LED.
  function automatic logic [13:0] rot_seed(input logic [13:0] v);
    return (v == 14'd0) ? 14'h0001 : v;
  endfunction

  function automatic logic [13:0] rotl1(input logic [13:0] v);
    return {v[12:0], v[13]};
  endfunction

  logic [SYNC_STAGES-1:0][15:0] sync_p;
  logic [15:0]                  sw_s;
  mode_t                        mode;
  mode_t                        mode_q;
  logic [CW-1:0]                presc;
  logic                         tick;
  logic [13:0]                  cnt;
  logic [13:0]                  cnt_nxt;
  logic [13:0]                  rot;
  logic [13:0]                  rot_nxt;
  logic [15:0]                  led_nxt;

  // Stage p0..pN: switch synchroniser chain, newest sample enters at index 0
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      sync_p <= '0;
    end else begin
      sync_p <= {sync_p[SYNC_STAGES-2:0], sw};
    end
  end

  assign sw_s = sync_p[SYNC_STAGES-1];
  assign mode = mode_t'(sw_s[15:14]);

  // Free-running prescaler; tick runs in every mode so animation phase is
  // independent of when a mode was entered.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      presc <= '0;
    end else if (presc == TICK_LAST) begin
      presc <= '0;
    end else begin
      presc <= presc + CW'(1);
    end
  end

  assign tick = (presc == TICK_LAST);

  // Next-state values feed both the state registers and the LED register,
  // so an update is visible on the LEDs on the same edge it happens.
  always_comb begin
    cnt_nxt = cnt;
    rot_nxt = rot;
    led_nxt = '0;

    if (tick && (mode == MODE_CNT)) begin
      cnt_nxt = sw_s[0] ? (cnt - 14'd1) : (cnt + 14'd1);
    end

    if ((mode == MODE_ROT) && (mode_q != MODE_ROT)) begin
      rot_nxt = rot_seed(sw_s[13:0]);
    end else if (tick && (mode == MODE_ROT)) begin
      rot_nxt = rotl1(rot);
    end

    case (mode)
      MODE_PASS: led_nxt = {mode, sw_s[13:0]};
      MODE_CNT:  led_nxt = {mode, cnt_nxt};
      MODE_ROT:  led_nxt = {mode, rot_nxt};
      default:   led_nxt = {mode, ~sw_s[13:0]};
    endcase
  end

  // Output stage: state registers and the LED register
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      cnt    <= '0;
      rot    <= '0;
      mode_q <= MODE_PASS;
      LED    <= '0;
    end else begin
      cnt    <= cnt_nxt;
      rot    <= rot_nxt;
      mode_q <= mode;
      LED    <= led_nxt;
    end
  end

endmodule

// File: tb/tb_basys3_top.sv
// tb_basys3_top -- self-checking bench for basys3_top (TICK_DIV=4,
// SYNC_STAGES=2). A behavioural model predicts LED after every rising edge
// from the switch history, the edge count since reset and plain integer
// arithmetic; a vector table and a few hand sequences pin down the
// documented corner cases.

module tb_basys3_top;

  localparam int TD = 4;
  localparam int SS = 2;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [15:0] sw = 16'h0000;
  logic [15:0] led;

  basys3_top #(.SYNC_STAGES(SS), .TICK_DIV(TD)) dut (
    .CLK100MHZ (clk),
    .CPU_RESETN(rstn),
    .sw        (sw),
    .LED       (led)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state
  int          k;        // rising edges since reset release
  int          cnt_m;
  int          rot_m;
  int          prev_m;
  logic [15:0] exp_led;
  logic [15:0] swq[$];   // switch samples still travelling through the synchroniser

  typedef struct {
    logic [15:0] sw;
    int          edges;
    logic [15:0] led;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: LED=%h expected %h at %0t", name, act, want, $time);
    end
  endtask

  task automatic model_reset();
    k       = 0;
    cnt_m   = 0;
    rot_m   = 0;
    prev_m  = 0;
    exp_led = 16'h0000;
    swq     = {};
    repeat (SS) swq.push_back(16'h0000);
  endtask

  task automatic model_edge();
    logic [15:0] s;
    int          md;
    bit          tk;
    int          low;
    k++;
    s  = swq[0];
    md = int'(s[15:14]);
    tk = ((k - 1) % TD) == (TD - 1);
    if (md == 1 && tk)
      cnt_m = s[0] ? (cnt_m + 16383) % 16384 : (cnt_m + 1) % 16384;
    if (md == 2) begin
      if (prev_m != 2)
        rot_m = (s[13:0] == 14'd0) ? 1 : int'(s[13:0]);
      else if (tk)
        rot_m = ((rot_m * 2) % 16384) + (rot_m / 8192);
    end
    prev_m = md;
    case (md)
      0:       low = int'(s[13:0]);
      1:       low = cnt_m;
      2:       low = rot_m;
      default: low = 16383 - int'(s[13:0]);
    endcase
    exp_led = 16'(md * 16384 + low);
    void'(swq.pop_front());
    swq.push_back(sw);
  endtask

  // One rising edge: advance the model, then sample the DUT 1 ns later.
  task automatic step(input bit chk);
    @(posedge clk);
    if (rstn) model_edge();
    #1;
    if (chk) check("model", led, exp_led);
  endtask

  task automatic do_reset(input int n);
    rstn = 1'b0;
    #1;
    check("rst_async", led, 16'h0000);
    model_reset();
    repeat (n) step(1);
    rstn = 1'b1;
  endtask

  initial begin
    logic [15:0] seq [6];
    int unsigned m;
    int unsigned v;
    int unsigned n;

    tbl.push_back('{16'h1234,  3, 16'h1234});
    tbl.push_back('{16'hFFFF,  3, 16'hC000});
    tbl.push_back('{16'hC0F0,  3, 16'hFF0F});
    tbl.push_back('{16'hA5A5,  3, 16'hA5A5});
    tbl.push_back('{16'hA5A5,  4, 16'h8B4B});
    tbl.push_back('{16'hA5A5, 56, 16'hA5A5});
    tbl.push_back('{16'h8000,  3, 16'h8001});
    tbl.push_back('{16'h5A5A,  3, 16'h4000});
    tbl.push_back('{16'h5A5A,  4, 16'h4001});
    tbl.push_back('{16'h5A5A,  8, 16'h4002});
    tbl.push_back('{16'h5A5A, 12, 16'h4003});
    tbl.push_back('{16'h4001,  4, 16'h7FFF});
    tbl.push_back('{16'h4001,  8, 16'h7FFE});
    tbl.push_back('{16'h0000, 10, 16'h0000});

    model_reset();
    #2;

    // Reset held with all switches on, then released with switches off.
    sw = 16'hFFFF;
    do_reset(4);
    sw = 16'h0000;
    rstn = 1'b0;
    #1;
    model_reset();
    rstn = 1'b1;
    repeat (10) step(1);
    check("rst_release", led, 16'h0000);

    // Vector table: each record starts from a fresh reset.
    foreach (tbl[i]) begin
      do_reset(2);
      sw = tbl[i].sw;
      repeat (tbl[i].edges) step(1);
      check($sformatf("vec%0d", i), led, tbl[i].led);
    end

    // Pass-through latency: nothing before the 3rd edge.
    do_reset(2);
    sw = 16'h1234;
    repeat (2) step(1);
    check("early", led, 16'h0000);
    step(1);
    check("latency", led, 16'h1234);

    // Reset asserted mid-animation clears LED before the next edge.
    do_reset(2);
    sw = 16'hA5A5;
    repeat (10) step(1);
    #2;
    rstn = 1'b0;
    #1;
    check("rst_mid", led, 16'h0000);
    model_reset();
    sw = 16'hFFFF;
    repeat (3) step(1);
    check("rst_hold", led, 16'h0000);
    sw = 16'h0000;
    rstn = 1'b1;
    repeat (10) step(1);
    check("rst_release2", led, 16'h0000);

    // Counter holds while away from mode 01 and resumes afterwards.
    do_reset(2);
    sw = 16'h5A5A;
    repeat (12) step(1);
    check("cnt_before", led, 16'h4003);
    sw = 16'h0000;
    repeat (20) step(1);
    sw = 16'h5A5A;
    repeat (3) step(1);
    check("cnt_resume", led, 16'h4003);
    step(1);
    check("cnt_resume_tick", led, 16'h4004);

    // Mode sequence, 100 clocks per setting; rotate reloads on re-entry.
    seq[0] = 16'h0000; seq[1] = 16'hA5A5; seq[2] = 16'h5A5A;
    seq[3] = 16'hFFFF; seq[4] = 16'h0000; seq[5] = 16'hA5A5;
    do_reset(2);
    for (int i = 0; i < 6; i++) begin
      sw = seq[i];
      if (i == 5) begin
        repeat (3) step(1);
        check("reload", led, 16'hA5A5);
        repeat (97) step(1);
      end else begin
        repeat (100) step(1);
      end
      check($sformatf("seq_mode%0d", i), {14'd0, led[15:14]}, {14'd0, seq[i][15:14]});
    end

    // Randomised switch activity with occasional resets.
    do_reset(2);
    for (int i = 0; i < 150; i++) begin
      m = $urandom_range(0, 3);
      v = $urandom;
      sw = {m[1:0], v[13:0]};
      if ($urandom_range(0, 7) == 0) sw[13:0] = 14'd0;
      if ($urandom_range(0, 3) == 0) sw[0] = ~sw[0];
      n = $urandom_range(1, 30);
      repeat (n) step(1);
      if ($urandom_range(0, 19) == 0) do_reset($urandom_range(1, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
